// File: rtl/dcache_ctrl_pkg.sv
// ============================================================================
// dcache_ctrl_pkg : shared encodings and helpers for the data cache controller
// Revision        : 1.0
// ============================================================================
`default_nettype none

package dcache_ctrl_pkg;

    localparam int LINE_BITS = 128;
    localparam int OFFSET_W  = 4;

    localparam logic RNW_READ  = 1'b1;
    localparam logic RNW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WB        = 2'd1,
        ST_FILL_REQ  = 2'd2,
        ST_FILL_WAIT = 2'd3
    } state_e;

    // Byte-enable merge of one 32-bit store word into a 128-bit line.
    function automatic logic [LINE_BITS-1:0] merge_line(
        input logic [LINE_BITS-1:0] line,
        input logic [1:0]           ws,
        input logic [3:0]           be,
        input logic [31:0]          din
    );
        logic [LINE_BITS-1:0] res;
        res = line;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[32*int'(ws) + 8*b +: 8] = din[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_ctrl_array.sv
// ============================================================================
// dcache_array : tag/valid/dirty/data storage, async read, sync write
// Revision     : 1.0
// ============================================================================
`default_nettype none

module dcache_array
    import dcache_ctrl_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 32 - OFFSET_W - IDX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     idx_i,
    output logic [TAG_W-1:0]     tag_o,
    output logic                 valid_o,
    output logic                 dirty_o,
    output logic [LINE_BITS-1:0] line_o,
    input  logic                 fill_en_i,
    input  logic [TAG_W-1:0]     fill_tag_i,
    input  logic [LINE_BITS-1:0] fill_line_i,
    input  logic                 merge_en_i,
    input  logic [1:0]           merge_ws_i,
    input  logic [3:0]           merge_be_i,
    input  logic [31:0]          merge_din_i,
    input  logic                 clr_dirty_i
);

    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [LINE_BITS-1:0] data_q [LINES];
    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     dirty_q;

    assign tag_o   = tag_q[idx_i];
    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign line_o  = data_q[idx_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (merge_en_i) begin
            dirty_q[idx_i] <= 1'b1;
        end else if (clr_dirty_i) begin
            dirty_q[idx_i] <= 1'b0;
        end
    end

    // Payload arrays carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_line_i;
        end else if (merge_en_i) begin
            data_q[idx_i] <= merge_line(data_q[idx_i], merge_ws_i, merge_be_i, merge_din_i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ============================================================================
// dcache_ctrl : direct-mapped write-back/write-allocate data cache controller
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int LINES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          dcache_addr,
    input  logic [3:0]           dcache_we,
    input  logic                 dcache_re,
    input  logic [31:0]          dcache_din,
    output logic [31:0]          dcache_dout,
    output logic                 stall,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_rnw,
    output logic [27:0]          mem_req_addr,
    output logic [LINE_BITS-1:0] mem_req_wdata,
    input  logic                 mem_resp_valid,
    input  logic [LINE_BITS-1:0] mem_resp_data
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - OFFSET_W - IDX_W;

    state_e state_q, state_d;

    logic        req_valid_q;
    logic [31:2] req_addr_q;
    logic [3:0]  req_we_q;
    logic [31:0] req_din_q;

    logic                 unused_addr_lsb;
    logic [IDX_W-1:0]     req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [1:0]           req_ws;
    logic                 req_store;
    logic [TAG_W-1:0]     arr_tag;
    logic                 arr_valid;
    logic                 arr_dirty;
    logic [LINE_BITS-1:0] arr_line;
    logic                 hit;
    logic                 miss;
    logic                 capture;
    logic                 fill_en;
    logic                 merge_en;
    logic                 clr_dirty;

    assign unused_addr_lsb = ^dcache_addr[1:0];

    assign req_idx   = req_addr_q[OFFSET_W+IDX_W-1:OFFSET_W];
    assign req_tag   = req_addr_q[31:OFFSET_W+IDX_W];
    assign req_ws    = req_addr_q[3:2];
    assign req_store = |req_we_q;

    assign hit      = req_valid_q && arr_valid && (arr_tag == req_tag);
    assign miss     = req_valid_q && !hit;
    assign stall    = (state_q != ST_IDLE) || miss;
    assign capture  = (state_q == ST_IDLE) && !stall && (dcache_re || (|dcache_we));
    assign merge_en = hit && req_store && (state_q == ST_IDLE);

    assign dcache_dout = (hit && !req_store) ? arr_line[{req_ws, 5'd0} +: 32] : 32'd0;

    dcache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .idx_i       (req_idx),
        .tag_o       (arr_tag),
        .valid_o     (arr_valid),
        .dirty_o     (arr_dirty),
        .line_o      (arr_line),
        .fill_en_i   (fill_en),
        .fill_tag_i  (req_tag),
        .fill_line_i (mem_resp_data),
        .merge_en_i  (merge_en),
        .merge_ws_i  (req_ws),
        .merge_be_i  (req_we_q),
        .merge_din_i (req_din_q),
        .clr_dirty_i (clr_dirty)
    );

    // While stalled the captured request is held so the post-fill re-lookup hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!stall) begin
                req_valid_q <= capture;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            req_addr_q <= dcache_addr[31:2];
            req_we_q   <= dcache_we;
            req_din_q  <= dcache_din;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req_valid = 1'b0;
        mem_req_rnw   = RNW_READ;
        mem_req_addr  = req_addr_q[31:4];
        mem_req_wdata = '0;
        fill_en       = 1'b0;
        clr_dirty     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (miss) begin
                    state_d = (arr_valid && arr_dirty) ? ST_WB : ST_FILL_REQ;
                end
            end
            ST_WB: begin
                mem_req_valid = 1'b1;
                mem_req_rnw   = RNW_WRITE;
                mem_req_addr  = {arr_tag, req_idx};
                mem_req_wdata = arr_line;
                if (mem_req_ready) begin
                    clr_dirty = 1'b1;
                    state_d   = ST_FILL_REQ;
                end
            end
            ST_FILL_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = ST_FILL_WAIT;
                end
            end
            ST_FILL_WAIT: begin
                if (mem_resp_valid) begin
                    fill_en = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire
